// File: rtl/pixel_writer_pkg.sv
// Shared graphics definitions: screen geometry, widths, pixel record and address helpers.
package pixel_writer_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int ADDR_W  = 19;
  localparam int COLOR_W = 12;

  typedef struct packed {
    logic [9:0]         x;
    logic [9:0]         y;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  localparam int PIXEL_W = $bits(pixel_t);

  function automatic logic is_clipped(input pixel_t p);
    return (p.x >= 10'(H_RES)) || (p.y >= 10'(V_RES));
  endfunction

  // y*640 + x as two shifts; off-screen rows can overflow, result is truncated.
  function automatic logic [ADDR_W-1:0] pixel_addr(input pixel_t p);
    logic [ADDR_W+1:0] w_sum;
    w_sum = ({11'd0, p.y} << 9) + ({11'd0, p.y} << 7) + {11'd0, p.x};
    return w_sum[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with full/empty flags; head entry is read combinationally.
module pixel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/pixel_writer.sv
// Buffers incoming pixels, clips them to the screen and issues one framebuffer write per visible pixel.
import pixel_writer_pkg::*;

module pixel_writer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_in_rts,
  output logic               o_in_rtr,
  input  logic [9:0]         i_px_x,
  input  logic [9:0]         i_px_y,
  input  logic [COLOR_W-1:0] i_px_color,
  output logic               o_mem_rts,
  input  logic               i_mem_rtr,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [COLOR_W-1:0] o_mem_data,
  output logic               o_busy,
  output logic [15:0]        o_clip_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  pixel_t              w_in_px;
  pixel_t              w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_load;
  logic                w_drop;
  logic                w_retire;
  logic [0:0]          w_state_nxt;

  logic [0:0]          r_state;
  logic                r_valid;
  logic                r_clip;
  logic [ADDR_W-1:0]   r_addr;
  logic [COLOR_W-1:0]  r_data;
  logic [15:0]         r_clip_count;

  assign w_in_px  = '{x: i_px_x, y: i_px_y, color: i_px_color};
  assign o_in_rtr = !w_full;
  assign w_push   = i_in_rts && o_in_rtr;

  pixel_fifo #(
    .WIDTH (PIXEL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_din   (w_in_px),
    .i_pop   (w_load),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A clipped entry sits in the stage for one cycle, then is discarded.
  assign w_drop   = r_valid && r_clip && (r_state == ST_IDLE);
  assign w_retire = w_drop || ((r_state == ST_REQ) && i_mem_rtr);
  assign w_load   = (!r_valid || w_retire) && !w_empty;

  always_comb begin
    w_state_nxt = r_state;
    if (w_load) begin
      w_state_nxt = is_clipped(w_head) ? ST_IDLE : ST_REQ;
    end else if (w_retire) begin
      w_state_nxt = ST_IDLE;
    end else if ((r_state == ST_IDLE) && r_valid && !r_clip) begin
      w_state_nxt = ST_REQ;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_valid      <= 1'b0;
      r_clip       <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_clip_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_valid <= 1'b1;
        r_clip  <= is_clipped(w_head);
        r_addr  <= pixel_addr(w_head);
        r_data  <= w_head.color;
      end else if (w_retire) begin
        r_valid <= 1'b0;
      end
      if (w_drop && (r_clip_count != 16'hFFFF)) r_clip_count <= r_clip_count + 16'd1;
    end
  end

  assign o_mem_rts    = (r_state == ST_REQ);
  assign o_mem_addr   = r_addr;
  assign o_mem_data   = r_data;
  assign o_busy       = !w_empty || r_valid;
  assign o_clip_count = r_clip_count;

endmodule
